// File: rtl/shift_reg_seq_pkg.sv
// Shared definitions for the shift-register sequencer: state encoding and
// the shift-count width derivation.
package shift_reg_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  localparam int unsigned DefaultRegWidth = 8;

  // Enough bits to hold any count from 0 up to and including reg_width.
  function automatic int unsigned cnt_width(input int unsigned reg_width);
    return $clog2(reg_width + 1);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter holding the number of shift cycles still to issue.
// Saturates at zero.
module seq_down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Moore sequencer that drives an external shift register through a
// load / shift-N / done cycle per accepted command, with abort support.
module shift_reg_sequencer
  import shift_reg_seq_pkg::*;
#(
  parameter int unsigned REG_WIDTH = DefaultRegWidth,
  parameter int unsigned CNT_WIDTH = cnt_width(REG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [REG_WIDTH-1:0] cmd_data,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  input  logic                 abort,
  output logic                 load,
  output logic                 shift_en,
  output logic                 shift_left_right,
  output logic [REG_WIDTH-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam logic [CNT_WIDTH-1:0] MaxCount = CNT_WIDTH'(REG_WIDTH);

  seq_state_e           state_q, state_d;
  logic [REG_WIDTH-1:0] data_q, data_d;
  logic                 dir_q, dir_d;
  logic                 aborted_q, aborted_d;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] count_clamped;
  logic                 accept;

  assign count_clamped = (cmd_count > MaxCount) ? MaxCount : cmd_count;
  assign accept        = (state_q == StIdle) && cmd_valid;

  seq_down_counter #(
    .Width(CNT_WIDTH)
  ) u_remaining (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (accept),
    .load_val_i(count_clamped),
    .dec_i     (state_q == StShift),
    .count_o   (remaining)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StLoad;
          data_d    = cmd_data;
          dir_d     = cmd_dir;
          aborted_d = 1'b0;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else begin
          state_d = (remaining != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        // The final shift completes normally even if abort arrives with it.
        if (remaining == CNT_WIDTH'(1)) begin
          state_d = StDone;
        end else if (abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      data_q    <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    cmd_ready        = (state_q == StIdle);
    busy             = (state_q != StIdle);
    load             = (state_q == StLoad);
    shift_en         = (state_q == StShift);
    done             = (state_q == StDone);
    aborted          = (state_q == StDone) && aborted_q;
    data_in          = data_q;
    shift_left_right = dir_q;
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: timeline model checked every cycle, an
// external reference shift register, and directed literal scenarios.
module tb_shift_reg_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic       abort;
  logic       load;
  logic       shift_en;
  logic       shift_left_right;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       aborted;

  shift_reg_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_data        (cmd_data),
    .cmd_dir         (cmd_dir),
    .cmd_count       (cmd_count),
    .abort           (abort),
    .load            (load),
    .shift_en        (shift_en),
    .shift_left_right(shift_left_right),
    .data_in         (data_in),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference shift register controlled by the sequencer.
  logic [7:0] ref_sr;
  always @(posedge clk) begin
    if (load) ref_sr <= data_in;
    else if (shift_en) ref_sr <= shift_left_right ? (ref_sr << 1) : (ref_sr >> 1);
  end

  // Timeline model: a command accepted at edge acc has load in cycle acc+1,
  // shifts in acc+2..acc+1+k, done in acc+2+k, ready again from acc+3+k.
  int         cyc = 0;
  bit         m_act;
  int         m_acc;
  int         m_k;
  bit         m_ab;
  logic [7:0] m_data;
  logic       m_dir;
  int         m_edge;
  int         m_rel;

  initial begin
    m_act = 0; m_acc = 0; m_k = 0; m_ab = 0; m_data = '0; m_dir = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_act  = 0;
        m_ab   = 0;
        m_data = '0;
        m_dir  = 1'b0;
      end else begin
        m_edge = cyc;
        cyc    = cyc + 1;
        m_rel  = m_edge - m_acc;
        if (m_act && abort) begin
          if (m_rel == 1) begin
            m_ab = 1;
            m_k  = 0;
          end else if (m_rel >= 2 && m_rel <= 1 + m_k) begin
            m_ab = (m_rel != 1 + m_k);
            m_k  = m_rel - 1;
          end
        end
        if (m_act && m_rel >= 3 + m_k) m_act = 0;
        if (!m_act && cmd_valid) begin
          m_act  = 1;
          m_acc  = m_edge;
          m_data = cmd_data;
          m_dir  = cmd_dir;
          m_k    = (int'(cmd_count) > 8) ? 8 : int'(cmd_count);
          m_ab   = 0;
        end
      end
    end
  end

  int         c_rel;
  logic       e_load, e_shift, e_done, e_busy;
  logic [7:0] e_sr;

  initial begin
    forever begin
      @(negedge clk);
      c_rel   = cyc - m_acc;
      e_load  = m_act && (c_rel == 1);
      e_shift = m_act && (c_rel >= 2) && (c_rel <= 1 + m_k);
      e_done  = m_act && (c_rel == 2 + m_k);
      e_busy  = m_act && (c_rel <= 2 + m_k);
      check("load", load, e_load);
      check("shift_en", shift_en, e_shift);
      check("done", done, e_done);
      check("busy", busy, e_busy);
      check("cmd_ready", cmd_ready, !e_busy);
      check("aborted", aborted, e_done && m_ab);
      check("data_in", data_in, m_data);
      check("shift_left_right", shift_left_right, m_dir);
      check("load_shift_excl", load & shift_en, 1'b0);
      if (e_done) begin
        e_sr = m_dir ? (m_data << m_k) : (m_data >> m_k);
        check("model_sr", ref_sr, e_sr);
      end
      if (done) done_cnt++;
    end
  end

  // Caller is at a negedge in an idle cycle; returns in the LOAD cycle.
  task automatic issue(input logic [7:0] d, input logic dir, input logic [3:0] c,
                       output int acc);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc - 1;
  endtask

  // Waits for done, checks latency/result, returns at the next (idle) negedge.
  task automatic wait_done(input string name, input int acc, input int exp_lat,
                           input logic [7:0] exp_sr, input logic exp_ab);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end else begin
      check({name, "_latency"}, cyc - acc, exp_lat);
      check({name, "_sr"}, ref_sr, exp_sr);
      check({name, "_aborted"}, aborted, exp_ab);
    end
    @(negedge clk);
  endtask

  int acc;
  int d0;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0; cmd_count = '0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_data_in", data_in, 8'h00);
    reset = 1'b0;

    // Accepted on the first edge after release.
    issue(8'b1010_0101, 1'b1, 4'd3, acc);
    wait_done("left3", acc, 5, 8'b0010_1000, 1'b0);

    issue(8'd1, 1'b0, 4'd0, acc);
    wait_done("count0", acc, 2, 8'd1, 1'b0);

    issue(8'hFF, 1'b1, 4'd15, acc);
    wait_done("clamp", acc, 10, 8'h00, 1'b0);

    issue(8'h3C, 1'b1, 4'd4, acc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_load", acc, 2, 8'h3C, 1'b1);

    issue(8'hF0, 1'b0, 4'd5, acc);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_2nd", acc, 4, 8'h3C, 1'b1);

    issue(8'hF0, 1'b0, 4'd5, acc);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_last", acc, 7, 8'h07, 1'b0);

    // Abort while idle must do nothing.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    @(negedge clk);

    // Back-to-back with cmd_valid held: accepts at X, X+5, X+10.
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_data = 8'h81; cmd_dir = 1'b1; cmd_count = 4'd2;
    repeat (15) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 3);

    // Reset in the middle of SHIFT.
    d0 = done_cnt;
    issue(8'hAA, 1'b1, 4'd6, acc);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_load", load, 1'b0);
    check("midrst_shift_en", shift_en, 1'b0);
    check("midrst_dir", shift_left_right, 1'b0);
    check("midrst_data_in", data_in, 8'h00);
    check("midrst_done", done, 1'b0);
    check("midrst_aborted", aborted, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    reset = 1'b0;
    issue(8'h0F, 1'b0, 4'd1, acc);
    wait_done("after_rst", acc, 3, 8'h07, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 Parameter REG_WIDTH, default 8: width of the controlled shift register and of data_in.
REQ-002 Parameter CNT_WIDTH, default $clog2(REG_WIDTH+1) = 4: width of the shift-count field.
REQ-003 clk  input  1: the single clock; all state changes occur on posedge clk.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 cmd_valid  input  1: a command is offered.
REQ-006 cmd_ready  output  1: the sequencer accepts a command this cycle.
REQ-007 cmd_data  input  REG_WIDTH: word to load into the shift register.
REQ-008 cmd_dir  input  1: shift direction, 1 = left, 0 = right.
REQ-009 cmd_count  input  CNT_WIDTH: number of shift cycles after the load.
REQ-010 abort  input  1: terminate the command in progress.
REQ-011 load  output  1: shift-register load strobe.
REQ-012 shift_en  output  1: shift-register shift enable.
REQ-013 shift_left_right  output  1: direction to the register (1 = left).
REQ-014 data_in  output  REG_WIDTH: parallel load word to the register.
REQ-015 busy  output  1: a command is in progress.
REQ-016 done  output  1: single-cycle completion pulse.
REQ-017 aborted  output  1: qualifies done; 1 = the command ended by abort.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE; all outputs SHALL be decoded from registered state only (Moore).
REQ-019 IDLE: cmd_ready=1; when cmd_valid&&cmd_ready at a posedge, the sequencer SHALL capture cmd_data, cmd_dir and min(cmd_count, REG_WIDTH) and go to LOAD.
REQ-020 A cmd_count above REG_WIDTH SHALL be clamped to REG_WIDTH.
REQ-021 LOAD (exactly 1 cycle): load=1, shift_en=0, data_in=captured word, shift_left_right=captured dir; next SHALL be SHIFT if count>0, else DONE.
REQ-022 SHIFT: load=0, shift_en=1, shift_left_right=captured dir for exactly count cycles, with the remaining counter decrementing each cycle; it SHALL go to DONE when remaining==1.
REQ-023 DONE (exactly 1 cycle): done=1, then IDLE.
REQ-024 cmd_ready SHALL be 0 and busy SHALL be 1 in LOAD, SHIFT and DONE; cmd_valid SHALL be ignored outside IDLE.
REQ-025 Latency: for a command accepted at edge N, load SHALL be high in cycle N+1, shifts in cycles N+2..N+1+count, done in cycle N+2+count, and cmd_ready high again in cycle N+3+count.
REQ-026 data_in and shift_left_right SHALL hold the captured values from LOAD through DONE; in IDLE they SHALL hold their last values.
REQ-027 abort sampled high in LOAD or SHIFT SHALL force DONE next cycle with aborted=1; the shift_en already asserted in that cycle stands.
REQ-028 abort coinciding with the final SHIFT cycle (remaining==1) SHALL yield aborted=0.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 load and shift_en SHALL never be high in the same cycle.

Reset
REQ-031 Reset assertion SHALL immediately force IDLE with load=0, shift_en=0, shift_left_right=0, data_in=0, done=0, aborted=0, busy=0 and cmd_ready=1, including mid-command; the interrupted command SHALL NOT produce done.
REQ-032 After reset release, the first posedge SHALL be able to accept a command.

Structure
REQ-033 The state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3) and the CNT_WIDTH derivation SHALL live in the shared package shift_reg_seq_pkg.
REQ-034 The remaining-shift counter SHALL be a sub-module seq_down_counter: loadable, decrementing, with async reset.
REQ-035 The controlled shift register SHALL NOT be inside this block; the bench SHALL instantiate a left/right shift register with load as the reference model.

Verification
REQ-036 Load 8'b1010_0101, dir=1, count=3 -> load in cycle N+1, 3 shift_en cycles, done in cycle N+5; the model register reads 8'b0010_1000.
REQ-037 Load 8'd1, dir=0, count=0 -> load, then done in cycle N+2 with no shift_en; the register reads 8'd1.
REQ-038 count=15, dir=1, data 8'hFF -> clamped to 8 shifts, done in cycle N+10; the register reads 8'h00.
REQ-039 count=5, abort in the 2nd SHIFT cycle -> 2 shifts, done with aborted=1; abort in the 5th SHIFT cycle -> aborted=0.
REQ-040 Reset asserted mid-SHIFT -> all outputs at reset values immediately, no done; a new command is accepted on the first edge after release.
REQ-041 Back-to-back commands with cmd_valid held high -> each accepted only in IDLE; load/shift_en are never both high.
